alu_datapath: RTL and testbench
===============================

# alu_datapath

Register/arithmetic datapath of the 8-bit ALU, steered cycle by cycle by the ALU control unit.
- Holds accumulator A, multiplier/quotient Q, multiplicand/divisor M, quotient-digit register QP and two 3-bit step counters.
- Provides a 9-bit add/subtract adder, radix-2 Booth recoding and the 16-bit result bus.
- Flags are returned to the control unit for sequencing multiply/divide.

## Interface
No parameters; widths are fixed. Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- load_reg_A, load_reg_Q, load_reg_M, load_reg_QP, load_cnt  in  1 each  register/counter loads.
- lshift_A, rshift_A, a7_mem, lshift_Q, rshift_Q, lshift_M, lshift_QP, c_up_QP  in  1 each  shift/increment controls.
- c_up_cnt1, c_down_cnt1, c_up_cnt2  in  1 each  counter controls.
- exor_in  in  1  subtract: invert adder y operand, carry-in = 1.
- sel_bus_mux1, sel_bus_mux2, sel_bus_mux3, sel_bus_mux5, sel_bus_mux6, sel_bus_mux7  in  1 each  mux selects.
- sel_bus_demux_1, sel_bus_demux_2, sel_bus_demux_3  in  1 each  demux selects.
- operand1, operand2  in  8 each  ALU operands.
- booth_digit_for_Q, booth_digit_for_QP  in  1 each  shift-in bits.
- outbus  out  16  ALU result.
- rega, regq  out  9 each  register contents.
- regM, regQP  out  8 each  register contents.
- sum  out  9  adder result.
- cout  out  1  adder carry-out.
- cnt1_out, cnt2_out  out  3 each  counter values.
- cnt7, cnt0  out  1 each  flags: CNT2==7, CNT1==0.
- booth_digits  out  3  one-hot: [2]=+1, [1]=0, [0]=-1.
- m7, a8  out  1 each  M[7], A[8].
- not_regA, not_regQ, not_regM, not_regQP, not_cnt1_out, not_cnt2_out  out  width as source  bitwise inverses (see Configuration).

## Operation
Steering conventions:
- Mux: sel=0 selects the first-listed input, sel=1 the second.
- Demux: the selected leg carries the input; the other leg is 0.

Datapath:
- demux1: Q[8:1]. 0 → adder leg; 1 → outbus[7:0] (that bus is 0 when demux1=0).
- demux2: A. 0 → adder leg; 1 → output leg.
- demux3: sum. 0 → A leg; 1 → Q leg.
- Adder x, mux5: A leg (0) or {0, Q leg} (1).
- Adder y, mux3: {0,QP} (0) or {0,M} (1). Each bit is XORed with exor_in.
- Adder: sum = x + y' + exor_in, truncated to 9 bits; cout = carry out of bit 8.
- A load source, mux1: demux3 A leg (0) or 9'b0 (1).
- Q load source: {mux2, 1'b0}; mux2 = operand1 (0) or demux3 Q leg [7:0] (1).
- outbus[15:8], mux7: demux2 output leg [7:0] (0) or {8{Q[8]}} (1).
- Booth input, mux6: A[8:6] (0) or {Q[1],Q[0],Q[0]} (1).
- Booth encoding: 000 and 111 → 0; 001, 010, 011 → +1; 100, 101, 110 → −1.

Register updates. Per register, priority is rst_n, then load, then shift, then count.
- A: load from mux1.
  - rshift_A: {a7_mem ? A[8] : 0, A[8:1]}.
  - lshift_A: {A[7:0], Q[8]}.
- Q: load.
  - lshift_Q: Q[8:1] ← {Q[7:1], entry} and Q[0] ← 0. The entry is M[7] when lshift_M=1, otherwise booth_digit_for_Q.
  - rshift_Q: {A[0], Q[8:1]}.
- M: load operand2; lshift_M: {M[6:0], 0}.
- QP: load clears to 0.
  - lshift_QP: {QP[6:0], booth_digit_for_QP}.
  - c_up_QP: +1 mod 256.
- Counters: load_cnt clears both.
  - Up/down count modulo 8 with wrap.
  - c_up_cnt1 and c_down_cnt1 together → hold.
- Left and right shift on the same register in the same cycle → hold.

## Timing
- All state changes on the rising edge of clk.
- Every output is combinational from the registers and the selects, visible in the same cycle.
- Reset (async, active-low):
  - A, Q, M, QP, CNT1, CNT2 = 0.
  - Hence cnt0=1, cnt7=0, booth_digits=010 (with mux6=0), m7=a8=0.
  - Asserting reset mid-operation aborts the operation immediately.
- Shifts using a neighbour register's bit (A←Q[8], Q←A[0]) sample the pre-edge value, so simultaneous A/Q shifts act as one 18-bit shift.

## Configuration
- ALU_DP_INV_OUTPUTS_EN defined: all not_* ports exist and equal the bitwise inverse of their source.
- ALU_DP_INV_OUTPUTS_EN undefined: the not_* ports are omitted.

## Structure
- Shared package alu_dp_pkg:
  - width constants: 8 for the data word, 9 for the extended A/Q/sum.
  - Booth one-hot constants: BOOTH_POS=3'b100, BOOTH_ZERO=3'b010, BOOTH_NEG=3'b001.
- One sub-module: booth_encoder (3-bit group → one-hot digit).
- Muxes, demuxes, registers and the adder are inline.

## Test plan
- Reset: rst_n=0 → all register outputs 0, cnt0=1, cnt7=0, booth_digits=3'b010.
- Load: operand1=0x90, operand2=0x05; load_reg_Q, load_reg_M and load_reg_A with mux1=1 for one cycle → regq=0x120, regM=0x05, rega=0.
- Arithmetic: A=0x003, mux3=1, mux5=0, demux2=0.
  - exor_in=0 → sum=0x008, cout=0.
  - exor_in=1 → sum=0x1FE, cout=0.
- Shifts: A=0, Q=0x120, lshift_A and lshift_Q, entry 0 → rega=0x001, regq=0x040. Then rshift_A with a7_mem=1 on A=0x100 → 0x180.
- Booth: mux6=1.
  - Q[1:0]=2'b10 → 3'b001.
  - Q[1:0]=2'b01 → 3'b100.
  - Q[1:0]=2'b11 → 3'b010.
- Counters: load_cnt.
  - Then 7 cycles of c_up_cnt2 → cnt7=1, and an 8th wraps to 0.
  - c_down_cnt1 from 0 → cnt1_out=7, cnt0=0.

Source files
------------

// File: rtl/alu_dp_pkg.sv
// Shared widths, types and Booth digit encodings for the ALU datapath.
package alu_dp_pkg;

    localparam int unsigned DataW = 8;
    localparam int unsigned ExtW  = 9;

    typedef logic [DataW-1:0] word_t;
    typedef logic [ExtW-1:0]  ext_t;
    typedef logic [2:0]       cnt_t;

    localparam logic [2:0] BOOTH_POS  = 3'b100;
    localparam logic [2:0] BOOTH_ZERO = 3'b010;
    localparam logic [2:0] BOOTH_NEG  = 3'b001;

endpackage

// File: rtl/alu_datapath_if.sv
// Control/status bundle between the ALU control unit (master) and the datapath (slave).
// ALU_DP_INV_OUTPUTS_EN adds the bitwise-inverted not_* status signals.
interface alu_datapath_if;
    import alu_dp_pkg::*;

    logic load_reg_A, load_reg_Q, load_reg_M, load_reg_QP, load_cnt;
    logic lshift_A, rshift_A, a7_mem, lshift_Q, rshift_Q, lshift_M, lshift_QP, c_up_QP;
    logic c_up_cnt1, c_down_cnt1, c_up_cnt2;
    logic exor_in;
    logic sel_bus_mux1, sel_bus_mux2, sel_bus_mux3, sel_bus_mux5, sel_bus_mux6, sel_bus_mux7;
    logic sel_bus_demux_1, sel_bus_demux_2, sel_bus_demux_3;
    word_t operand1, operand2;
    logic booth_digit_for_Q, booth_digit_for_QP;

    logic [15:0] outbus;
    ext_t        rega, regq, sum;
    word_t       regM, regQP;
    logic        cout;
    cnt_t        cnt1_out, cnt2_out;
    logic        cnt7, cnt0;
    logic [2:0]  booth_digits;
    logic        m7, a8;
`ifdef ALU_DP_INV_OUTPUTS_EN
    ext_t        not_regA, not_regQ;
    word_t       not_regM, not_regQP;
    cnt_t        not_cnt1_out, not_cnt2_out;
`endif

    modport master (
        output load_reg_A, load_reg_Q, load_reg_M, load_reg_QP, load_cnt,
        output lshift_A, rshift_A, a7_mem, lshift_Q, rshift_Q, lshift_M, lshift_QP, c_up_QP,
        output c_up_cnt1, c_down_cnt1, c_up_cnt2, exor_in,
        output sel_bus_mux1, sel_bus_mux2, sel_bus_mux3, sel_bus_mux5, sel_bus_mux6,
        output sel_bus_mux7, sel_bus_demux_1, sel_bus_demux_2, sel_bus_demux_3,
        output operand1, operand2, booth_digit_for_Q, booth_digit_for_QP,
        input  outbus, rega, regq, regM, regQP, sum, cout, cnt1_out, cnt2_out,
        input  cnt7, cnt0, booth_digits, m7, a8
`ifdef ALU_DP_INV_OUTPUTS_EN
        , input not_regA, not_regQ, not_regM, not_regQP, not_cnt1_out, not_cnt2_out
`endif
    );

    modport slave (
        input  load_reg_A, load_reg_Q, load_reg_M, load_reg_QP, load_cnt,
        input  lshift_A, rshift_A, a7_mem, lshift_Q, rshift_Q, lshift_M, lshift_QP, c_up_QP,
        input  c_up_cnt1, c_down_cnt1, c_up_cnt2, exor_in,
        input  sel_bus_mux1, sel_bus_mux2, sel_bus_mux3, sel_bus_mux5, sel_bus_mux6,
        input  sel_bus_mux7, sel_bus_demux_1, sel_bus_demux_2, sel_bus_demux_3,
        input  operand1, operand2, booth_digit_for_Q, booth_digit_for_QP,
        output outbus, rega, regq, regM, regQP, sum, cout, cnt1_out, cnt2_out,
        output cnt7, cnt0, booth_digits, m7, a8
`ifdef ALU_DP_INV_OUTPUTS_EN
        , output not_regA, not_regQ, not_regM, not_regQP, not_cnt1_out, not_cnt2_out
`endif
    );

endinterface

// File: rtl/booth_encoder.sv
// Radix-2 Booth recoder: 3-bit window to one-hot digit {+1, 0, -1}.
module booth_encoder
    import alu_dp_pkg::*;
(
    input  logic [2:0] triplet,
    output logic [2:0] digit
);

    always_comb begin
        digit = BOOTH_ZERO;
        unique case (triplet)
            3'b000, 3'b111:         digit = BOOTH_ZERO;
            3'b001, 3'b010, 3'b011: digit = BOOTH_POS;
            default:                digit = BOOTH_NEG;
        endcase
    end

endmodule

// File: rtl/alu_datapath.sv
// 8-bit ALU datapath: A/Q/M/QP registers, step counters, 9-bit adder and result bus.
// ALU_DP_INV_OUTPUTS_EN drives the not_* inverted status outputs.
module alu_datapath
    import alu_dp_pkg::*;
(
    input logic           clk,
    input logic           rst_n,
    alu_datapath_if.slave bus
);

    ext_t  a_q, a_d, q_q, q_d;
    word_t m_q, m_d, qp_q, qp_d;
    cnt_t  cnt1_q, cnt1_d, cnt2_q, cnt2_d;

    word_t          q_hi, q_leg, out_lo, a_out, sum_q_leg, q_src, out_hi;
    ext_t           a_leg, x_op, y_op, sum, sum_a_leg, a_load;
    logic [ExtW:0]  sum_full;
    logic [2:0]     booth_in;
    logic           q_entry;

    // Demux legs: the unselected leg is forced to zero.
    assign q_hi      = q_q[ExtW-1:1];
    assign q_leg     = bus.sel_bus_demux_1 ? '0 : q_hi;
    assign out_lo    = bus.sel_bus_demux_1 ? q_hi : '0;
    assign a_leg     = bus.sel_bus_demux_2 ? '0 : a_q;
    assign a_out     = bus.sel_bus_demux_2 ? a_q[DataW-1:0] : '0;

    assign x_op      = bus.sel_bus_mux5 ? {1'b0, q_leg} : a_leg;
    assign y_op      = (bus.sel_bus_mux3 ? {1'b0, m_q} : {1'b0, qp_q}) ^ {ExtW{bus.exor_in}};
    assign sum_full  = {1'b0, x_op} + {1'b0, y_op} + {{ExtW{1'b0}}, bus.exor_in};
    assign sum       = sum_full[ExtW-1:0];

    assign sum_a_leg = bus.sel_bus_demux_3 ? '0 : sum;
    assign sum_q_leg = bus.sel_bus_demux_3 ? sum[DataW-1:0] : '0;
    assign a_load    = bus.sel_bus_mux1 ? '0 : sum_a_leg;
    assign q_src     = bus.sel_bus_mux2 ? sum_q_leg : bus.operand1;
    assign out_hi    = bus.sel_bus_mux7 ? {DataW{q_q[ExtW-1]}} : a_out;
    assign booth_in  = bus.sel_bus_mux6 ? {q_q[1], q_q[0], q_q[0]} : a_q[ExtW-1:ExtW-3];
    assign q_entry   = bus.lshift_M ? m_q[DataW-1] : bus.booth_digit_for_Q;

    booth_encoder u_booth (
        .triplet (booth_in),
        .digit   (bus.booth_digits)
    );

    // Neighbour bits come from the pre-edge registers, so A/Q shifts chain as one 18-bit shift.
    always_comb begin
        a_d = a_q;
        if (bus.load_reg_A)                    a_d = a_load;
        else if (bus.lshift_A && bus.rshift_A) a_d = a_q;
        else if (bus.rshift_A)                 a_d = {bus.a7_mem & a_q[ExtW-1], a_q[ExtW-1:1]};
        else if (bus.lshift_A)                 a_d = {a_q[ExtW-2:0], q_q[ExtW-1]};

        q_d = q_q;
        if (bus.load_reg_Q)                    q_d = {q_src, 1'b0};
        else if (bus.lshift_Q && bus.rshift_Q) q_d = q_q;
        else if (bus.lshift_Q)                 q_d = {q_q[ExtW-2:1], q_entry, 1'b0};
        else if (bus.rshift_Q)                 q_d = {a_q[0], q_q[ExtW-1:1]};

        m_d = m_q;
        if (bus.load_reg_M)    m_d = bus.operand2;
        else if (bus.lshift_M) m_d = {m_q[DataW-2:0], 1'b0};

        qp_d = qp_q;
        if (bus.load_reg_QP)     qp_d = '0;
        else if (bus.lshift_QP)  qp_d = {qp_q[DataW-2:0], bus.booth_digit_for_QP};
        else if (bus.c_up_QP)    qp_d = qp_q + 8'd1;

        cnt1_d = cnt1_q;
        cnt2_d = cnt2_q;
        if (bus.load_cnt) begin
            cnt1_d = '0;
            cnt2_d = '0;
        end else begin
            if (bus.c_up_cnt1 && !bus.c_down_cnt1)      cnt1_d = cnt1_q + 3'd1;
            else if (bus.c_down_cnt1 && !bus.c_up_cnt1) cnt1_d = cnt1_q - 3'd1;
            if (bus.c_up_cnt2)                          cnt2_d = cnt2_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            q_q    <= '0;
            m_q    <= '0;
            qp_q   <= '0;
            cnt1_q <= '0;
            cnt2_q <= '0;
        end else begin
            a_q    <= a_d;
            q_q    <= q_d;
            m_q    <= m_d;
            qp_q   <= qp_d;
            cnt1_q <= cnt1_d;
            cnt2_q <= cnt2_d;
        end
    end

    assign bus.outbus   = {out_hi, out_lo};
    assign bus.rega     = a_q;
    assign bus.regq     = q_q;
    assign bus.regM     = m_q;
    assign bus.regQP    = qp_q;
    assign bus.sum      = sum;
    assign bus.cout     = sum_full[ExtW];
    assign bus.cnt1_out = cnt1_q;
    assign bus.cnt2_out = cnt2_q;
    assign bus.cnt7     = (cnt2_q == 3'd7);
    assign bus.cnt0     = (cnt1_q == 3'd0);
    assign bus.m7       = m_q[DataW-1];
    assign bus.a8       = a_q[ExtW-1];

`ifdef ALU_DP_INV_OUTPUTS_EN
    assign bus.not_regA     = ~a_q;
    assign bus.not_regQ     = ~q_q;
    assign bus.not_regM     = ~m_q;
    assign bus.not_regQP    = ~qp_q;
    assign bus.not_cnt1_out = ~cnt1_q;
    assign bus.not_cnt2_out = ~cnt2_q;
`endif

endmodule

// File: tb/tb_alu_datapath.sv
// Self-checking bench for alu_datapath: directed steps, then random control against an arithmetic model.
module tb_alu_datapath;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    // Reference state as plain integers.
    int ma, mq, mm, mqp, mc1, mc2;
    int e_sum, e_cout, e_outbus, e_booth;

    always #5 clk = ~clk;

    alu_datapath_if bus ();

    alu_datapath dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic clear_ctl();
        bus.load_reg_A = 0; bus.load_reg_Q = 0; bus.load_reg_M = 0; bus.load_reg_QP = 0;
        bus.load_cnt = 0; bus.lshift_A = 0; bus.rshift_A = 0; bus.a7_mem = 0;
        bus.lshift_Q = 0; bus.rshift_Q = 0; bus.lshift_M = 0; bus.lshift_QP = 0;
        bus.c_up_QP = 0; bus.c_up_cnt1 = 0; bus.c_down_cnt1 = 0; bus.c_up_cnt2 = 0;
        bus.exor_in = 0; bus.sel_bus_mux1 = 0; bus.sel_bus_mux2 = 0; bus.sel_bus_mux3 = 0;
        bus.sel_bus_mux5 = 0; bus.sel_bus_mux6 = 0; bus.sel_bus_mux7 = 0;
        bus.sel_bus_demux_1 = 0; bus.sel_bus_demux_2 = 0; bus.sel_bus_demux_3 = 0;
        bus.operand1 = 0; bus.operand2 = 0; bus.booth_digit_for_Q = 0;
        bus.booth_digit_for_QP = 0;
    endtask

    task automatic rand_ctl();
        bus.load_reg_A = ($urandom_range(3) == 0); bus.load_reg_Q = ($urandom_range(3) == 0);
        bus.load_reg_M = ($urandom_range(3) == 0); bus.load_reg_QP = ($urandom_range(5) == 0);
        bus.load_cnt = ($urandom_range(7) == 0);
        bus.lshift_A = 1'($urandom); bus.rshift_A = 1'($urandom); bus.a7_mem = 1'($urandom);
        bus.lshift_Q = 1'($urandom); bus.rshift_Q = 1'($urandom); bus.lshift_M = 1'($urandom);
        bus.lshift_QP = 1'($urandom); bus.c_up_QP = 1'($urandom);
        bus.c_up_cnt1 = 1'($urandom); bus.c_down_cnt1 = 1'($urandom);
        bus.c_up_cnt2 = 1'($urandom); bus.exor_in = 1'($urandom);
        bus.sel_bus_mux1 = 1'($urandom); bus.sel_bus_mux2 = 1'($urandom);
        bus.sel_bus_mux3 = 1'($urandom); bus.sel_bus_mux5 = 1'($urandom);
        bus.sel_bus_mux6 = 1'($urandom); bus.sel_bus_mux7 = 1'($urandom);
        bus.sel_bus_demux_1 = 1'($urandom); bus.sel_bus_demux_2 = 1'($urandom);
        bus.sel_bus_demux_3 = 1'($urandom);
        bus.operand1 = 8'($urandom); bus.operand2 = 8'($urandom);
        bus.booth_digit_for_Q = 1'($urandom); bus.booth_digit_for_QP = 1'($urandom);
    endtask

    task automatic mdl_reset();
        ma = 0; mq = 0; mm = 0; mqp = 0; mc1 = 0; mc2 = 0;
    endtask

    // Expected combinational outputs from model state and current controls.
    task automatic mdl_comb();
        int x, y, t, g, hi, lo;
        if (bus.sel_bus_mux5) x = bus.sel_bus_demux_1 ? 0 : mq / 2;
        else                  x = bus.sel_bus_demux_2 ? 0 : ma;
        y = bus.sel_bus_mux3 ? mm : mqp;
        if (bus.exor_in) y = 511 - y;
        t = x + y + int'(bus.exor_in);
        e_sum  = t % 512;
        e_cout = t / 512;
        lo = bus.sel_bus_demux_1 ? mq / 2 : 0;
        if (bus.sel_bus_mux7) hi = (mq >= 256) ? 255 : 0;
        else                  hi = bus.sel_bus_demux_2 ? ma % 256 : 0;
        e_outbus = hi * 256 + lo;
        g = bus.sel_bus_mux6 ? ((mq / 2) % 2) * 4 + (mq % 2) * 3 : ma / 64;
        if (g == 0 || g == 7) e_booth = 2;
        else if (g < 4)       e_booth = 4;
        else                  e_booth = 1;
    endtask

    task automatic mdl_step();
        int na, nq, nm, nqp, ent;
        mdl_comb();
        na = ma; nq = mq; nm = mm; nqp = mqp;
        if (bus.load_reg_A)                    na = bus.sel_bus_mux1 ? 0 :
                                                    (bus.sel_bus_demux_3 ? 0 : e_sum);
        else if (bus.lshift_A && bus.rshift_A) na = ma;
        else if (bus.rshift_A)                 na = (bus.a7_mem ? (ma / 256) * 256 : 0) + ma / 2;
        else if (bus.lshift_A)                 na = (ma * 2) % 512 + mq / 256;
        if (bus.load_reg_Q) begin
            if (bus.sel_bus_mux2) nq = (bus.sel_bus_demux_3 ? e_sum % 256 : 0) * 2;
            else                  nq = int'(bus.operand1) * 2;
        end else if (bus.lshift_Q && bus.rshift_Q) nq = mq;
        else if (bus.lshift_Q) begin
            ent = bus.lshift_M ? mm / 128 : int'(bus.booth_digit_for_Q);
            nq = ((mq % 256) / 2) * 4 + ent * 2;
        end else if (bus.rshift_Q) nq = (ma % 2) * 256 + mq / 2;
        if (bus.load_reg_M)    nm = int'(bus.operand2);
        else if (bus.lshift_M) nm = (mm * 2) % 256;
        if (bus.load_reg_QP)    nqp = 0;
        else if (bus.lshift_QP) nqp = (mqp * 2) % 256 + int'(bus.booth_digit_for_QP);
        else if (bus.c_up_QP)   nqp = (mqp + 1) % 256;
        if (bus.load_cnt) begin
            mc1 = 0; mc2 = 0;
        end else begin
            if (bus.c_up_cnt1 && !bus.c_down_cnt1)      mc1 = (mc1 + 1) % 8;
            else if (bus.c_down_cnt1 && !bus.c_up_cnt1) mc1 = (mc1 + 7) % 8;
            if (bus.c_up_cnt2)                          mc2 = (mc2 + 1) % 8;
        end
        ma = na; mq = nq; mm = nm; mqp = nqp;
    endtask

    task automatic check_all();
        mdl_comb();
        check("rega", 16'(bus.rega), 16'(ma));
        check("regq", 16'(bus.regq), 16'(mq));
        check("regM", 16'(bus.regM), 16'(mm));
        check("regQP", 16'(bus.regQP), 16'(mqp));
        check("cnt1", 16'(bus.cnt1_out), 16'(mc1));
        check("cnt2", 16'(bus.cnt2_out), 16'(mc2));
        check("cnt0", 16'(bus.cnt0), 16'(mc1 == 0));
        check("cnt7", 16'(bus.cnt7), 16'(mc2 == 7));
        check("m7", 16'(bus.m7), 16'(mm / 128));
        check("a8", 16'(bus.a8), 16'(ma / 256));
        check("sum", 16'(bus.sum), 16'(e_sum));
        check("cout", 16'(bus.cout), 16'(e_cout));
        check("outbus", bus.outbus, 16'(e_outbus));
        check("booth", 16'(bus.booth_digits), 16'(e_booth));
`ifdef ALU_DP_INV_OUTPUTS_EN
        check("not_regA", 16'(bus.not_regA), 16'(511 - ma));
        check("not_regQ", 16'(bus.not_regQ), 16'(511 - mq));
        check("not_regM", 16'(bus.not_regM), 16'(255 - mm));
        check("not_regQP", 16'(bus.not_regQP), 16'(255 - mqp));
        check("not_cnt1", 16'(bus.not_cnt1_out), 16'(7 - mc1));
        check("not_cnt2", 16'(bus.not_cnt2_out), 16'(7 - mc2));
`endif
    endtask

    // Controls are already driven; check outputs, advance model, cross one rising edge.
    task automatic cycle();
        #1;
        check_all();
        mdl_step();
        @(negedge clk);
        clear_ctl();
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_ctl();
        mdl_reset();
        #2;
        check("rst_rega", 16'(bus.rega), 16'h0);
        check("rst_regq", 16'(bus.regq), 16'h0);
        check("rst_regM", 16'(bus.regM), 16'h0);
        check("rst_regQP", 16'(bus.regQP), 16'h0);
        check("rst_cnt0", 16'(bus.cnt0), 16'h1);
        check("rst_cnt7", 16'(bus.cnt7), 16'h0);
        check("rst_booth", 16'(bus.booth_digits), 16'h2);
        @(negedge clk);
        rst_n = 1'b1;

        // Load Q, M and clear A together
        bus.operand1 = 8'h90; bus.operand2 = 8'h05;
        bus.load_reg_Q = 1; bus.load_reg_M = 1; bus.load_reg_A = 1; bus.sel_bus_mux1 = 1;
        cycle();
        check("load_regq", 16'(bus.regq), 16'h120);
        check("load_regM", 16'(bus.regM), 16'h05);
        check("load_rega", 16'(bus.rega), 16'h0);

        // Build A=3 through the adder, then restore M=5
        bus.operand2 = 8'h03; bus.load_reg_M = 1;
        cycle();
        bus.load_reg_A = 1; bus.sel_bus_mux3 = 1;
        cycle();
        bus.operand2 = 8'h05; bus.load_reg_M = 1;
        cycle();
        check("setup_rega", 16'(bus.rega), 16'h003);
        bus.sel_bus_mux3 = 1;
        #1;
        check("add_sum", 16'(bus.sum), 16'h008);
        check("add_cout", 16'(bus.cout), 16'h0);
        bus.exor_in = 1;
        #1;
        check("sub_sum", 16'(bus.sum), 16'h1FE);
        check("sub_cout", 16'(bus.cout), 16'h0);
        clear_ctl();

        // Shifts
        bus.load_reg_A = 1; bus.sel_bus_mux1 = 1;
        cycle();
        bus.lshift_A = 1; bus.lshift_Q = 1;
        cycle();
        check("lsh_rega", 16'(bus.rega), 16'h001);
        check("lsh_regq", 16'(bus.regq), 16'h040);
        for (int i = 0; i < 8; i++) begin
            bus.lshift_A = 1;
            cycle();
        end
        check("lsh8_rega", 16'(bus.rega), 16'h100);
        bus.rshift_A = 1; bus.a7_mem = 1;
        cycle();
        check("rsh_rega", 16'(bus.rega), 16'h180);

        // Booth digits from Q
        bus.operand1 = 8'h01; bus.load_reg_Q = 1;
        cycle();
        bus.sel_bus_mux6 = 1; #1;
        check("booth_10", 16'(bus.booth_digits), 16'h1);
        bus.rshift_Q = 1;
        cycle();
        bus.sel_bus_mux6 = 1; #1;
        check("booth_01", 16'(bus.booth_digits), 16'h4);
        bus.sel_bus_mux6 = 0;
        bus.operand1 = 8'h03; bus.load_reg_Q = 1;
        cycle();
        bus.rshift_Q = 1;
        cycle();
        bus.sel_bus_mux6 = 1; #1;
        check("booth_11", 16'(bus.booth_digits), 16'h2);
        clear_ctl();

        // Counters
        bus.load_cnt = 1;
        cycle();
        for (int i = 0; i < 7; i++) begin
            bus.c_up_cnt2 = 1;
            cycle();
        end
        check("cnt2_7", 16'(bus.cnt2_out), 16'h7);
        check("cnt7_set", 16'(bus.cnt7), 16'h1);
        bus.c_up_cnt2 = 1;
        cycle();
        check("cnt2_wrap", 16'(bus.cnt2_out), 16'h0);
        check("cnt7_clr", 16'(bus.cnt7), 16'h0);
        bus.c_down_cnt1 = 1;
        cycle();
        check("cnt1_down", 16'(bus.cnt1_out), 16'h7);
        check("cnt0_clr", 16'(bus.cnt0), 16'h0);

        // Random control sequences against the model
        for (int i = 0; i < 400; i++) begin
            rand_ctl();
            cycle();
        end

        // Asynchronous reset mid-operation
        rand_ctl();
        bus.load_reg_M = 1; bus.operand2 = 8'hA5;
        #1;
        rst_n = 1'b0;
        mdl_reset();
        #1;
        check("arst_rega", 16'(bus.rega), 16'h0);
        check("arst_regq", 16'(bus.regq), 16'h0);
        check("arst_regM", 16'(bus.regM), 16'h0);
        check("arst_cnt0", 16'(bus.cnt0), 16'h1);
        @(negedge clk);
        clear_ctl();
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            rand_ctl();
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
